// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit multiplexed seven-segment scanner with frame-aligned shadow
//
// Ports:
//   clk        : single clock
//   reset      : synchronous active-high reset
//   value_in   : four hex digits, digit0 = [3:0]
//   seg        : registered segment drive {g,f,e,d,c,b,a}
//   dig_en     : registered one-hot digit enable, bit n = digit n
//   frame_tick : one-cycle pulse in the first cycle of each frame (shadow just loaded)
//
// Optional feature: define SEVEN_SEG_SCAN_LZB_EN to blank leading zero digits
// (digit0 is never blanked; digit enables keep their normal timing).

module seven_seg_scan #(
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en,
    output logic        frame_tick
);

    localparam int              CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [6:0]      SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]      DIG_OFF    = ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } slot_state_t;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow;
    slot_state_t      state;
    slot_state_t      state_next;

    logic             cnt_wrap;
    logic             frame_end;
    logic [3:0]       nibble;
    logic [6:0]       glyph;
    logic             lead_blank;
    logic [6:0]       seg_next;
    logic [3:0]       dig_next;

    assign cnt_wrap  = (cnt == CNT_LAST);
    assign frame_end = cnt_wrap && (idx == 2'd3);

    // Prescaler, digit index and frame shadow. The shadow only moves at the
    // frame boundary so a mid-frame value_in change never tears a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= 16'h0000;
            frame_tick <= 1'b0;
            state      <= ST_BLANK;
        end else begin
            cnt        <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) begin
                idx <= idx + 2'd1;
            end
            if (frame_end) begin
                shadow <= value_in;
            end
            frame_tick <= frame_end;
            state      <= state_next;
        end
    end

    // Slot phase: BLANK covers cnt 0..BLANK_CYC-1, SHOW the rest of the slot.
    always_comb begin
        state_next = state;
        case (state)
            ST_BLANK: if (cnt == BLANK_LAST) state_next = ST_SHOW;
            ST_SHOW:  if (cnt_wrap)          state_next = ST_BLANK;
            default:  state_next = ST_BLANK;
        endcase
    end

    assign nibble = shadow[{idx, 2'b00} +: 4];

    always_comb begin
        glyph = 7'h00;
        case (nibble)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    end

`ifdef SEVEN_SEG_SCAN_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lead_blank = 1'b0;
        case (idx)
            2'd1:    lead_blank = (shadow[15:4]  == 12'h000);
            2'd2:    lead_blank = (shadow[15:8]  == 8'h00);
            2'd3:    lead_blank = (shadow[15:12] == 4'h0);
            default: lead_blank = 1'b0;
        endcase
    end
`else
    assign lead_blank = 1'b0;
`endif

    // Output drive for the next cycle. BLANK at every slot start guarantees the
    // old digit is released before the next one is enabled.
    always_comb begin
        seg_next = SEG_OFF;
        dig_next = DIG_OFF;
        if (state == ST_SHOW) begin
            dig_next = ACTIVE_LOW ? ~(4'b0001 << idx) : (4'b0001 << idx);
            if (!lead_blank) begin
                seg_next = ACTIVE_LOW ? ~glyph : glyph;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg    <= SEG_OFF;
            dig_en <= DIG_OFF;
        end else begin
            seg    <= seg_next;
            dig_en <= dig_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan (CLK_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1)

module tb_seven_seg_scan;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_scan #(
        .CLK_DIV    (CLK_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] font [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference: position in the frame since reset release, the frame's value,
    // and the pins expected one cycle after each position.
    int          m_pos;
    logic [15:0] m_shadow;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_ft;

    function automatic logic [10:0] model_pins(int pos, logic [15:0] sh);
        int         phase;
        int         slot;
        logic [3:0] nib;
        logic       lead;
        phase = pos % CLK_DIV;
        slot  = (pos / CLK_DIV) % 4;
        nib   = sh[4*slot +: 4];
        lead  = 1'b0;
`ifdef SEVEN_SEG_SCAN_LZB_EN
        lead  = (slot > 0) && ((sh >> (4 * slot)) == 16'h0000);
`endif
        if (phase < BLANK_CYC)
            return {7'h7F, 4'hF};
        return {(lead ? 7'h7F : ~font[nib]), ~(4'b0001 << slot)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pos    <= 0;
            m_shadow <= 16'h0000;
            exp_seg  <= 7'h7F;
            exp_dig  <= 4'hF;
            exp_ft   <= 1'b0;
        end else begin
            {exp_seg, exp_dig} <= model_pins(m_pos, m_shadow);
            exp_ft <= (m_pos % FRAME == FRAME - 1);
            if (m_pos % FRAME == FRAME - 1)
                m_shadow <= value_in;
            m_pos <= m_pos + 1;
        end
    end

    task automatic wait_tick(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_tick_timeout: frame_tick actual=0 required=1 within %0d cycles", name, 3 * FRAME);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        value_in = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: actual=%h required=7f", seg); end
            n_checks++;
            if (dig_en !== 4'hF) begin n_fail++; $display("FAIL reset_dig_en: actual=%h required=f", dig_en); end
            n_checks++;
            if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick: actual=%b required=0", frame_tick); end
        end
        reset = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            n_checks++;
            if (dig_en !== 4'hF && seg !== 7'h40) begin
                n_fail++; $display("FAIL reset_first_frame_zero k=%0d: seg actual=%h required=40", k, seg);
            end
            n_checks++;
            if (dig_en !== exp_dig || seg !== exp_seg) begin
                n_fail++; $display("FAIL reset_model k=%0d: dig/seg actual=%h/%h required=%h/%h", k, dig_en, seg, exp_dig, exp_seg);
            end
            n_checks++;
            if (frame_tick !== (k == FRAME)) begin
                n_fail++; $display("FAIL reset_first_tick k=%0d: actual=%b required=%b", k, frame_tick, k == FRAME);
            end
        end
    endtask

    task automatic test_steady();
        logic [3:0] dig_tab [0:3] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] seg_tab [0:3] = '{7'h03, 7'h08, 7'h24, 7'h79};
        bit ok;
        value_in = 16'h12AB;
        wait_tick("steady", ok);
        if (ok) begin
            for (int j = 1; j <= FRAME; j++) begin
                @(negedge clk);
                if ((j - 1) % CLK_DIV < BLANK_CYC) begin
                    n_checks++;
                    if (dig_en !== 4'hF || seg !== 7'h7F) begin
                        n_fail++; $display("FAIL steady_blank j=%0d: dig/seg actual=%h/%h required=f/7f", j, dig_en, seg);
                    end
                end else begin
                    n_checks++;
                    if (dig_en !== dig_tab[(j - 1) / CLK_DIV] || seg !== seg_tab[(j - 1) / CLK_DIV]) begin
                        n_fail++; $display("FAIL steady_show j=%0d: dig/seg actual=%h/%h required=%h/%h", j, dig_en, seg,
                                           dig_tab[(j - 1) / CLK_DIV], seg_tab[(j - 1) / CLK_DIV]);
                    end
                end
            end
        end
    endtask

    task automatic test_frame_align();
        bit ok;
        value_in = 16'h1234;
        wait_tick("align", ok);
        if (ok) begin
            repeat (10) @(negedge clk);
            value_in = 16'h5678;
            for (int j = 11; j <= FRAME; j++) begin
                @(negedge clk);
                n_checks++;
                case (dig_en)
                    4'hD: if (seg !== 7'h30) begin n_fail++; $display("FAIL align_old_d1: seg actual=%h required=30", seg); end
                    4'hB: if (seg !== 7'h24) begin n_fail++; $display("FAIL align_old_d2: seg actual=%h required=24", seg); end
                    4'h7: if (seg !== 7'h79) begin n_fail++; $display("FAIL align_old_d3: seg actual=%h required=79", seg); end
                    4'hF: if (seg !== 7'h7F) begin n_fail++; $display("FAIL align_old_blank: seg actual=%h required=7f", seg); end
                    default: begin n_fail++; $display("FAIL align_old_dig j=%0d: dig_en actual=%h required=d/b/7/f", j, dig_en); end
                endcase
                n_checks++;
                if (frame_tick !== (j == FRAME)) begin
                    n_fail++; $display("FAIL align_tick j=%0d: actual=%b required=%b", j, frame_tick, j == FRAME);
                end
            end
            for (int j = 1; j < FRAME; j++) begin
                @(negedge clk);
                n_checks++;
                case (dig_en)
                    4'hE: if (seg !== 7'h00) begin n_fail++; $display("FAIL align_new_d0: seg actual=%h required=00", seg); end
                    4'hD: if (seg !== 7'h78) begin n_fail++; $display("FAIL align_new_d1: seg actual=%h required=78", seg); end
                    4'hB: if (seg !== 7'h02) begin n_fail++; $display("FAIL align_new_d2: seg actual=%h required=02", seg); end
                    4'h7: if (seg !== 7'h12) begin n_fail++; $display("FAIL align_new_d3: seg actual=%h required=12", seg); end
                    4'hF: if (seg !== 7'h7F) begin n_fail++; $display("FAIL align_new_blank: seg actual=%h required=7f", seg); end
                    default: begin n_fail++; $display("FAIL align_new_dig j=%0d: dig_en actual=%h", j, dig_en); end
                endcase
            end
        end
    endtask

    task automatic test_timing();
        int  last_tick = -1;
        bit  prev_ft = 1'b0;
        for (int c = 0; c < 8 * FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (dig_en !== exp_dig || seg !== exp_seg || frame_tick !== exp_ft) begin
                n_fail++; $display("FAIL timing_model c=%0d: dig/seg/tick actual=%h/%h/%b required=%h/%h/%b",
                                   c, dig_en, seg, frame_tick, exp_dig, exp_seg, exp_ft);
            end
            n_checks++;
            if ($countones(~dig_en) > 1) begin
                n_fail++; $display("FAIL timing_onehot c=%0d: dig_en actual=%h required at most one low bit", c, dig_en);
            end
            if (frame_tick === 1'b1) begin
                n_checks++;
                if (prev_ft) begin n_fail++; $display("FAIL timing_tick_width c=%0d: actual=2+ cycles required=1", c); end
                if (last_tick >= 0) begin
                    n_checks++;
                    if (c - last_tick != FRAME) begin
                        n_fail++; $display("FAIL timing_tick_period: actual=%0d required=%0d", c - last_tick, FRAME);
                    end
                end
                last_tick = c;
            end
            prev_ft = frame_tick;
            if ($urandom_range(0, 5) == 0)
                value_in = 16'($urandom);
        end
    endtask

    task automatic test_lzb();
        bit ok;
        logic [6:0] lead_seg;
`ifdef SEVEN_SEG_SCAN_LZB_EN
        lead_seg = 7'h7F;
`else
        lead_seg = 7'h40;
`endif
        value_in = 16'h0005;
        wait_tick("lzb", ok);
        if (ok) begin
            for (int j = 1; j < FRAME; j++) begin
                @(negedge clk);
                n_checks++;
                case (dig_en)
                    4'hE: if (seg !== 7'h12) begin n_fail++; $display("FAIL lzb_digit0: seg actual=%h required=12", seg); end
                    4'hD, 4'hB, 4'h7:
                        if (seg !== lead_seg) begin
                            n_fail++; $display("FAIL lzb_lead dig_en=%h: seg actual=%h required=%h", dig_en, seg, lead_seg);
                        end
                    4'hF: if (seg !== 7'h7F) begin n_fail++; $display("FAIL lzb_blank: seg actual=%h required=7f", seg); end
                    default: begin n_fail++; $display("FAIL lzb_dig j=%0d: dig_en actual=%h", j, dig_en); end
                endcase
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        value_in = 16'hBEEF;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (m_pos % FRAME == 2 * CLK_DIV + 5) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL midreset_locate: idx=2 cnt=5 actual=not reached required=reached");
        end else begin
            reset = 1'b1;
            @(negedge clk);
            n_checks++;
            if (seg !== 7'h7F || dig_en !== 4'hF || frame_tick !== 1'b0) begin
                n_fail++; $display("FAIL midreset_outputs: seg/dig/tick actual=%h/%h/%b required=7f/f/0", seg, dig_en, frame_tick);
            end
            reset = 1'b0;
            for (int k = 1; k <= FRAME; k++) begin
                @(negedge clk);
                n_checks++;
                if (frame_tick !== (k == FRAME)) begin
                    n_fail++; $display("FAIL midreset_tick k=%0d: actual=%b required=%b", k, frame_tick, k == FRAME);
                end
                n_checks++;
                if (dig_en !== 4'hF && seg !== 7'h40) begin
                    n_fail++; $display("FAIL midreset_zero k=%0d: seg actual=%h required=40", k, seg);
                end
                n_checks++;
                if (dig_en !== exp_dig || seg !== exp_seg) begin
                    n_fail++; $display("FAIL midreset_model k=%0d: dig/seg actual=%h/%h required=%h/%h", k, dig_en, seg, exp_dig, exp_seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_frame_align();
        test_timing();
        test_lzb();
        test_reset_mid();
        test_timing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
